// File: rtl/icache_refill_responder_if.sv
// Refill handshake and instruction-memory bus bundle for icache_refill_responder.
// The slave modport is the responder; the master modport drives the requester and bus side.
interface icache_refill_responder_if #(
    parameter int WORD       = 32,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
);
    logic                         memory_valid;
    logic [ADDR_W-1:0]            addr;
    logic                         memory_ready;
    logic [LINE_WORDS*WORD-1:0]   ret_line;
    logic                         mem_req;
    logic [ADDR_W-1:0]            mem_addr;
    logic                         mem_gnt;
    logic                         mem_rvalid;
    logic [WORD-1:0]              mem_rdata;

    modport slave (
        input  memory_valid, addr, mem_gnt, mem_rvalid, mem_rdata,
        output memory_ready, ret_line, mem_req, mem_addr
    );

    modport master (
        output memory_valid, addr, mem_gnt, mem_rvalid, mem_rdata,
        input  memory_ready, ret_line, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_refill_responder.sv
// Line-refill responder: fetches LINE_WORDS words over a single-outstanding bus and returns the line.
// Optional build macro CRITICAL_WORD_FIRST_EN starts the fetch at the missed word and wraps.
module icache_refill_responder #(
    parameter int WORD       = 32,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic clk,
    input  logic rstn,
    icache_refill_responder_if.slave bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF   = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [IDX_W-1:0]        cnt_reg, cnt_next;
    logic [ADDR_W-OFF-1:0]   tag_reg, tag_next;
    logic [ADDR_W-1:0]       mem_addr_reg, mem_addr_next;
    logic [IDX_W-1:0]        start_idx;
    logic [IDX_W-1:0]        idx_inc;
    logic                    capture;
    logic                    unused_low_bits;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_idx = bus.addr[OFF-1:2];
`else
    assign start_idx = '0;
`endif
    assign unused_low_bits = ^bus.addr[OFF-1:0];

    // Index arithmetic stays inside IDX_W bits, so the address wraps within the line.
    assign idx_inc = idx_reg + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            tag_reg      <= '0;
            mem_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            cnt_reg      <= cnt_next;
            tag_reg      <= tag_next;
            mem_addr_reg <= mem_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        cnt_next      = cnt_reg;
        tag_next      = tag_reg;
        mem_addr_next = mem_addr_reg;
        capture       = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (bus.memory_valid) begin
                    tag_next      = bus.addr[ADDR_W-1:OFF];
                    idx_next      = start_idx;
                    cnt_next      = '0;
                    mem_addr_next = {bus.addr[ADDR_W-1:OFF], start_idx, 2'b00};
                    state_next    = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    capture       = 1'b1;
                    idx_next      = idx_inc;
                    cnt_next      = cnt_reg + 1'b1;
                    mem_addr_next = {tag_reg, idx_inc, 2'b00};
                    state_next    = (cnt_reg == LAST_CNT) ? S_RESP : S_REQ;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.mem_req      = (state_reg == S_REQ);
    assign bus.memory_ready = (state_reg == S_RESP);
    assign bus.mem_addr     = mem_addr_reg;

    // Each line word only changes when its own index is returned, so the line persists between refills.
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
        logic [WORD-1:0] word_reg;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                word_reg <= '0;
            end else if (capture && (idx_reg == IDX_W'(gi))) begin
                word_reg <= bus.mem_rdata;
            end
        end
        assign bus.ret_line[gi*WORD +: WORD] = word_reg;
    end
endmodule
